// File: rtl/ymux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ymux_pkg
//  Purpose  : Shared constants and width helper for the ymux stream selector.
//  Revision : 1.0 - initial release
// ============================================================================
package ymux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width for n channels; never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : ymux_pkg
`default_nettype wire

// File: rtl/ymux_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : ymux_rr_pick
//  Purpose  : Combinational round-robin picker: first valid channel from ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module ymux_rr_pick
    import ymux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = clog2w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          found
);

    logic [N-1:0]  w_rot;
    logic [SW-1:0] w_off;
    logic [SW:0]   w_sum;

    always_comb begin
        // Rotate so that bit 0 is the channel at ptr, then take the lowest set bit.
        w_rot = N'({valid, valid} >> ptr);
        w_off = '0;
        found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                found = 1'b1;
                w_off = SW'(j);
            end
        end
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (SW + 1)'(N)) begin
            w_sum = w_sum - (SW + 1)'(N);
        end
        grant = w_sum[SW-1:0];
    end

endmodule : ymux_rr_pick
`default_nettype wire

// File: rtl/ymux_stream.sv
`default_nettype none
// ============================================================================
//  Module   : ymux_stream
//  Purpose  : N-to-1 valid/ready stream mux with registered output, fixed or
//             round-robin channel choice.
//  Revision : 1.0 - initial release
// ============================================================================
module ymux_stream
    import ymux_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int N    = 4,
    parameter  int MODE = MODE_FIXED,
    localparam int SW   = clog2w(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_chan
);

    logic [W-1:0]  r_data;
    logic          r_valid;
    logic [SW-1:0] r_chan;
    logic [SW-1:0] r_ptr;

    logic [SW-1:0] w_rr_grant;
    logic          w_rr_found;
    logic [SW-1:0] w_chan;
    logic          w_found;
    logic          w_open;
    logic          w_fire;
    logic [W-1:0]  w_word;
    logic [SW-1:0] w_ptr_next;

    ymux_rr_pick #(
        .N (N)
    ) u_rr_pick (
        .valid (in_valid),
        .ptr   (r_ptr),
        .grant (w_rr_grant),
        .found (w_rr_found)
    );

    always_comb begin
        w_chan  = sel;
        w_found = 1'b0;
        if (MODE == MODE_RR) begin
            w_chan  = w_rr_grant;
            w_found = w_rr_found;
        end else begin
            // Out-of-range sel matches no channel and therefore grants nothing.
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i)) begin
                    w_found = in_valid[i];
                end
            end
        end

        w_open = !r_valid || out_ready;
        w_fire = w_open && w_found && !reset;

        w_word   = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_chan == SW'(i)) begin
                w_word      = in_data[i*W +: W];
                in_ready[i] = w_fire;
            end
        end

        w_ptr_next = (w_chan == SW'(N - 1)) ? '0 : w_chan + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_ptr   <= '0;
        end else if (w_fire) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_chan  <= w_chan;
            if (MODE == MODE_RR) begin
                r_ptr <= w_ptr_next;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_chan  = r_chan;

endmodule : ymux_stream
`default_nettype wire

// File: tb/tb_ymux_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ymux_stream
//  Purpose  : Directed self-checking bench for ymux_stream (fixed, RR, N=5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ymux_stream;

    localparam logic [31:0] c_base4 = {8'h44, 8'hA5, 8'h22, 8'h11};
    localparam logic [39:0] c_base5 = {8'h55, 8'h44, 8'h33, 8'h66, 8'h77};

    logic        clk;
    logic        reset;
    logic        out_ready;
    logic [31:0] data4;
    logic [3:0]  valid4;
    logic [1:0]  sel_fix;
    logic [39:0] data5;
    logic [4:0]  valid5;
    logic [2:0]  sel5;

    logic [3:0] rdy_fix, rdy_rr;
    logic [7:0] od_fix, od_rr, od_n5;
    logic       ov_fix, ov_rr, ov_n5;
    logic [1:0] oc_fix, oc_rr;
    logic [4:0] rdy_n5;
    logic [2:0] oc_n5;

    int n_checks;
    int n_fail;

    logic [7:0] exp_byte [4];

    ymux_stream #(.W(8), .N(4), .MODE(0)) u_fix (
        .clk(clk), .reset(reset), .in_data(data4), .in_valid(valid4),
        .in_ready(rdy_fix), .sel(sel_fix), .out_data(od_fix),
        .out_valid(ov_fix), .out_ready(out_ready), .out_chan(oc_fix)
    );

    ymux_stream #(.W(8), .N(4), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in_data(data4), .in_valid(valid4),
        .in_ready(rdy_rr), .sel(sel_fix), .out_data(od_rr),
        .out_valid(ov_rr), .out_ready(out_ready), .out_chan(oc_rr)
    );

    ymux_stream #(.W(8), .N(5), .MODE(0)) u_n5 (
        .clk(clk), .reset(reset), .in_data(data5), .in_valid(valid5),
        .in_ready(rdy_n5), .sel(sel5), .out_data(od_n5),
        .out_valid(ov_n5), .out_ready(out_ready), .out_chan(oc_n5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_byte[0] = 8'h11;
        exp_byte[1] = 8'h22;
        exp_byte[2] = 8'hA5;
        exp_byte[3] = 8'h44;

        reset     = 1'b1;
        out_ready = 1'b0;
        data4     = c_base4;
        valid4    = 4'b1111;
        sel_fix   = 2'd2;
        data5     = c_base5;
        valid5    = 5'b00000;
        sel5      = 3'd0;

        // Reset state, inputs all valid
        #2;
        check("rst_ov_fix", ov_fix, 1'b0);
        check("rst_od_fix", od_fix, 8'h00);
        check("rst_oc_fix", oc_fix, 2'd0);
        check("rst_rdy_fix", rdy_fix, 4'b0000);
        check("rst_rdy_rr", rdy_rr, 4'b0000);
        tick();
        check("rst_ov_rr_edge", ov_rr, 1'b0);

        // Fixed select of channel 2
        #2;
        reset     = 1'b0;
        valid4    = 4'b0100;
        out_ready = 1'b1;
        #1;
        check("fix_rdy", rdy_fix, 4'b0100);
        check("rr_rdy_first", rdy_rr, 4'b0100);
        tick();
        check("fix_od", od_fix, 8'hA5);
        check("fix_oc", oc_fix, 2'd2);
        check("fix_ov", ov_fix, 1'b1);
        check("rr_oc_ch2", oc_rr, 2'd2);

        // Round-robin wrap from ptr=3 with only ch0/ch1 valid
        valid4 = 4'b0011;
        #1;
        check("rr_wrap_rdy0", rdy_rr, 4'b0001);
        tick();
        check("rr_wrap_oc0", oc_rr, 2'd0);
        check("rr_wrap_od0", od_rr, 8'h11);
        check("fix_drain_ov", ov_fix, 1'b0);
        check("fix_drain_od_hold", od_fix, 8'hA5);
        check("fix_drain_oc_hold", oc_fix, 2'd2);
        check("rr_wrap_rdy1", rdy_rr, 4'b0010);
        tick();
        check("rr_wrap_oc1", oc_rr, 2'd1);
        check("rr_wrap_od1", od_rr, 8'h22);
        check("rr_wrap_rdy0b", rdy_rr, 4'b0001);
        tick();
        check("rr_wrap_oc0b", oc_rr, 2'd0);

        // Back-pressure with toggling inputs
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid4 = (k % 2 == 0) ? 4'b1111 : 4'b1010;
            data4  = ~c_base4 + 32'(k);
            #1;
            check("stall_rdy", rdy_rr, 4'b0000);
            tick();
            check("stall_od", od_rr, 8'h11);
            check("stall_oc", oc_rr, 2'd0);
            check("stall_ov", ov_rr, 1'b1);
        end
        data4     = c_base4;
        valid4    = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("unstall_rdy", rdy_rr, 4'b0010);
        tick();
        check("unstall_oc", oc_rr, 2'd1);
        check("unstall_od", od_rr, 8'h22);

        // Asynchronous reset mid-cycle while holding a word
        reset = 1'b1;
        #1;
        check("async_ov", ov_rr, 1'b0);
        check("async_od", od_rr, 8'h00);
        check("async_oc", oc_rr, 2'd0);
        check("async_rdy", rdy_rr, 4'b0000);
        #1;
        reset = 1'b0;
        #1;

        // Continuous round-robin over all channels, starting at ch0
        for (int k = 0; k < 6; k++) begin
            check("rr_seq_rdy", rdy_rr, 32'(4'b0001 << (k % 4)));
            tick();
            check("rr_seq_oc", oc_rr, 32'(k % 4));
            check("rr_seq_od", od_rr, exp_byte[k % 4]);
            check("rr_seq_ov", ov_rr, 1'b1);
        end

        // N=5: valid sel, then out-of-range sel
        valid5 = 5'b11111;
        sel5   = 3'd1;
        #1;
        check("n5_rdy_sel1", rdy_n5, 5'b00010);
        tick();
        check("n5_ov", ov_n5, 1'b1);
        check("n5_oc", oc_n5, 3'd1);
        check("n5_od", od_n5, 8'h66);
        sel5 = 3'd5;
        #1;
        check("n5_rdy_sel5", rdy_n5, 5'b00000);
        tick();
        check("n5_drain_ov", ov_n5, 1'b0);
        check("n5_drain_od_hold", od_n5, 8'h66);
        sel5 = 3'd7;
        #1;
        check("n5_rdy_sel7", rdy_n5, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ymux_stream
`default_nettype wire
